// File: rtl/empaquetador_pkg.sv
// ============================================================================
// Module  : empaquetador_pkg
// Purpose : Shared widths, packing-phase encoding and default FIFO depth.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package empaquetador_pkg;

    localparam int SYM_W         = 2;
    localparam int WORD_W        = 8;
    localparam int SYMS_PER_WORD = 4;
    localparam int DEPTH_DEFAULT = 4;

    // Number of symbols already accepted for the word being assembled
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } phase_t;

endpackage

`default_nettype wire

// File: rtl/fifo_sincrona.sv
// ============================================================================
// Module  : fifo_sincrona
// Purpose : Synchronous first-word-fall-through FIFO with occupancy count.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sincrona #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]    C_FULL   = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap naturally
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == C_FULL);
    // Head is forced to zero when empty so reset presents a clean 8'h00
    assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/empaquetador_fifo.sv
// ============================================================================
// Module  : empaquetador_fifo
// Purpose : Packs four 2-bit symbols MSB-first into bytes, buffered in a FIFO.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module empaquetador_fifo
    import empaquetador_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic [SYM_W-1:0]         data_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    output logic [WORD_W-1:0]        data_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     error
);

    phase_t                   r_phase;
    logic [WORD_W-SYM_W-1:0]  r_partial;
    logic                     r_error;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    logic [WORD_W-1:0]        w_word;

    // Only registered state feeds ready_out; a same-edge pop cannot free a slot
    assign ready_out = !(w_full && (r_phase == S3));
    assign w_accept  = valid_in && ready_out;
    assign w_push    = w_accept && (r_phase == S3);
    assign w_pop     = valid_out && ready_in;
    assign w_word    = {r_partial, data_in};
    assign valid_out = !w_empty;
    assign error     = r_error;

    always_ff @(posedge clk) begin
        if (reset_L) begin
            r_phase   <= S0;
            r_partial <= '0;
            r_error   <= 1'b0;
        end else begin
            if (valid_in && !ready_out) r_error <= 1'b1;
            if (w_accept) begin
                case (r_phase)
                    S0: begin
                        r_partial[5:4] <= data_in;
                        r_phase        <= S1;
                    end
                    S1: begin
                        r_partial[3:2] <= data_in;
                        r_phase        <= S2;
                    end
                    S2: begin
                        r_partial[1:0] <= data_in;
                        r_phase        <= S3;
                    end
                    default: r_phase   <= S0;
                endcase
            end
        end
    end

    fifo_sincrona #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (w_push),
        .pop     (w_pop),
        .din     (w_word),
        .dout    (data_out),
        .count   (fifo_count),
        .empty   (w_empty),
        .full    (w_full)
    );

endmodule

`default_nettype wire

// File: tb/tb_empaquetador_fifo.sv
// ============================================================================
// Module  : tb_empaquetador_fifo
// Purpose : Directed self-checking bench for the symbol packer and its FIFO.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_empaquetador_fifo;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [1:0] data_in = 2'b00;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in = 1'b0;
    logic [2:0] fifo_count;
    logic       error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    empaquetador_fifo #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .fifo_count (fifo_count),
        .error      (error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_L  = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        step();
        reset_L  = 1'b0;
    endtask

    task automatic send_sym(input logic [1:0] s);
        valid_in = 1'b1;
        data_in  = s;
        step();
        valid_in = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        send_sym(w[7:6]);
        send_sym(w[5:4]);
        send_sym(w[3:2]);
        send_sym(w[1:0]);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_data",  32'(data_out),  32'h00);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_error", 32'(error),     32'd0);

        // Basic packing: 11,00,10,01 -> C9
        send_sym(2'b11); send_sym(2'b00); send_sym(2'b10);
        check("basic_notyet", 32'(valid_out), 32'd0);
        send_sym(2'b01);
        check("basic_valid", 32'(valid_out), 32'd1);
        check("basic_data",  32'(data_out),  32'hC9);
        check("basic_count", 32'(fifo_count), 32'd1);
        check("basic_error", 32'(error),     32'd0);

        // Fill FIFO, overflow at S3, then drain in order
        do_reset();
        send_word(8'h1B); send_word(8'hE4); send_word(8'hFF); send_word(8'h00);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_ready_s0", 32'(ready_out), 32'd1);
        send_sym(2'b10); send_sym(2'b10); send_sym(2'b10);
        check("full_ready_s3", 32'(ready_out), 32'd0);
        check("full_err_before", 32'(error), 32'd0);
        send_sym(2'b01);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'd4);
        ready_in = 1'b1;
        check("drain0", 32'(data_out), 32'h1B);
        step();
        check("drain1", 32'(data_out), 32'hE4);
        step();
        check("drain2", 32'(data_out), 32'hFF);
        step();
        check("drain3", 32'(data_out), 32'h00);
        step();
        check("drain_count", 32'(fifo_count), 32'd0);
        check("drain_valid", 32'(valid_out), 32'd0);
        check("drain_ready", 32'(ready_out), 32'd1);
        // Dropped symbol left phase at S3: one more symbol completes 10_10_10_11
        send_sym(2'b11);
        check("resume_data", 32'(data_out), 32'hAB);
        check("resume_count", 32'(fifo_count), 32'd1);
        check("sticky_error", 32'(error), 32'd1);
        step();
        check("resume_popped", 32'(valid_out), 32'd0);

        // Streaming with consumer always ready
        do_reset();
        ready_in = 1'b1;
        begin
            logic [1:0] syms [8]  = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00};
            logic [2:0] cnts [8]  = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1};
            valid_in = 1'b1;
            for (int i = 0; i < 8; i++) begin
                data_in = syms[i];
                step();
                check($sformatf("stream_cnt%0d", i), 32'(fifo_count), 32'(cnts[i]));
                if (i == 3) check("stream_w0", 32'(data_out), 32'h5A);
                if (i == 7) check("stream_w1", 32'(data_out), 32'h3C);
            end
            valid_in = 1'b0;
        end
        check("stream_error", 32'(error), 32'd0);

        // Gaps between symbols leave the word unchanged
        do_reset();
        send_sym(2'b11); send_sym(2'b00);
        step(); step(); step();
        send_sym(2'b10); send_sym(2'b01);
        check("gap_data",  32'(data_out),  32'hC9);
        check("gap_count", 32'(fifo_count), 32'd1);

        // Push and pop at the same edge with two words stored
        do_reset();
        send_word(8'h12); send_word(8'h34);
        check("pp_pre_count", 32'(fifo_count), 32'd2);
        send_sym(2'b01); send_sym(2'b01); send_sym(2'b01);
        ready_in = 1'b1;
        send_sym(2'b10);
        ready_in = 1'b0;
        check("pp_count", 32'(fifo_count), 32'd2);
        check("pp_head",  32'(data_out),  32'h34);
        step();
        check("pp_hold", 32'(data_out), 32'h34);

        // Reset mid-word with stored words, then a clean word
        do_reset();
        send_word(8'h12); send_word(8'h34); send_word(8'h56);
        send_sym(2'b11); send_sym(2'b11);
        check("mid_count", 32'(fifo_count), 32'd3);
        reset_L = 1'b1;
        step();
        reset_L = 1'b0;
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_valid", 32'(valid_out), 32'd0);
        check("mid_rst_data",  32'(data_out),  32'h00);
        check("mid_rst_error", 32'(error),     32'd0);
        send_word(8'h9C);
        check("fresh_data",  32'(data_out),  32'h9C);
        check("fresh_count", 32'(fifo_count), 32'd1);
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        check("fresh_empty", 32'(valid_out), 32'd0);
        check("fresh_count0", 32'(fifo_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/empaquetador_fifo.md
# empaquetador_fifo

Downstream stage of the 2-bit memory multiplexer. Collects the multiplexer's 2-bit output symbols, packs four consecutive symbols into one 8-bit word (MSB first), and buffers completed words in a small synchronous FIFO. The FIFO is drained by a consumer through a valid/ready handshake. A sticky error flag records any symbol that was offered while the block could not accept it.

## Interface
Parameters:
- DEPTH, 4, number of FIFO word entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_L  input  1  reset, synchronous, active-high (1 = reset); sampled on the clk rising edge only.
- data_in  input  2  symbol from the multiplexer stage (its data_out).
- valid_in  input  1  data_in holds a symbol this cycle.
- ready_out  output  1  block accepts a symbol this cycle.
- data_out  output  8  FIFO head word; first-word-fall-through.
- valid_out  output  1  FIFO non-empty; data_out is valid.
- ready_in  input  1  consumer takes data_out this cycle.
- fifo_count  output  $clog2(DEPTH)+1  words currently stored, 0..DEPTH.
- error  output  1  sticky overflow flag.

## Operation
- Accept: a symbol is accepted when valid_in=1 and ready_out=1 on a rising edge.
- Packing phase: sym_cnt is a 2-bit phase counter, S0..S3, holding the number of symbols already accepted for the current word.
  - S0: accepted symbol goes to word bits [7:6].
  - S1: accepted symbol goes to bits [5:4].
  - S2: accepted symbol goes to bits [3:2].
  - S3: accepted symbol completes the word as {partial[7:2], data_in}. The word is pushed to the FIFO at the same edge and sym_cnt wraps to S0.
  - Phase advances only on accept. Idle cycles (valid_in=0) hold the partial word and the phase.
- ready_out = !(fifo_count==DEPTH && sym_cnt==S3).
  - Combinational from registered state only; no path from ready_in.
  - A full FIFO still accepts symbols in S0–S2.
- Pop: occurs when valid_out=1 and ready_in=1. The head advances and the next word appears on data_out in the following cycle.
- Count: push only → +1; pop only → −1; push and pop in the same cycle → unchanged. Read and write pointers wrap modulo DEPTH.
- Overflow: valid_in=1 while ready_out=0.
  - The symbol is dropped.
  - Phase and partial word are unchanged.
  - error is set to 1 at that edge and stays 1 until reset.
- ready_in=1 while the FIFO is empty has no effect.
- Reset, when asserted at any edge, overrides every other event. Results:
  - sym_cnt=S0; partial word is discarded.
  - Pointers cleared; fifo_count=0.
  - valid_out=0, data_out=8'h00, ready_out=1, error=0.
  - An in-progress word or stored words are lost.

## Timing
- Latency: 4th symbol accepted at edge N with the FIFO empty → valid_out=1 and data_out valid from edge N through the next edge. The word is poppable at edge N+1.
- Throughput: 1 symbol per cycle in; at most 1 word per 4 cycles out at steady state.
- fifo_count, valid_out and error are registered or decoded from registers; all update one edge after the causing event.
- Full FIFO in S3 with a pop at the same edge: still not ready. Conservative; one symbol cycle is lost, with no combinational ready_in→ready_out path.

## Structure
- Shared package empaquetador_pkg:
  - SYM_W=2, WORD_W=8, SYMS_PER_WORD=4.
  - Phase encoding S0..S3.
  - DEPTH default.
- Sub-module fifo_sincrona (DEPTH, WIDTH=WORD_W):
  - Ports: push, pop, din, dout, count, empty, full; same clk/reset_L.
  - Implements the pointer and count logic above.
- Top level holds the packing phase, partial-word register, ready_out and the error logic.

## Test plan
- Reset then stream 2'b11,2'b00,2'b10,2'b01 with ready_in=0 → one edge after the 4th symbol: valid_out=1, data_out=8'hC9, fifo_count=1, error=0.
- Stream 16 symbols (four words 8'h1B,8'hE4,8'hFF,8'h00) with ready_in=0 (DEPTH=4) → fifo_count=4. Then offer one more word with valid_in=1: first 3 symbols accepted; at S3 ready_out=0, the 4th symbol is dropped and error=1. Raise ready_in → words pop in order 1B,E4,FF,00.
- Continuous valid_in with ready_in=1 → fifo_count never exceeds 1; each word appears one edge after its 4th symbol; error stays 0.
- valid_in gaps between symbols (e.g. 3 idle cycles after symbol 2) → word value identical to the gapless case.
- Push and pop at the same edge with fifo_count=2 → fifo_count stays 2; data_out advances to the next word.
- Assert reset_L after 2 symbols and with 3 words stored → next edge: fifo_count=0, valid_out=0, data_out=8'h00, error=0. A fresh 4-symbol sequence then yields exactly one correct word.
